// File: rtl/board_label_gen.sv
`default_nettype none
// ============================================================================
// Module   : board_label_gen
// Function : two-stage pipelined file (A-H) / rank (1-8) label generator for
//            the chessboard draw path; LABEL_FLIP_EN builds the board-flip FSM.
// Revision : 1.0
// ============================================================================
module board_label_gen #(
    parameter int BOARD_X   = 256,
    parameter int BOARD_Y   = 128,
    parameter int SQ_LOG2   = 6,
    parameter int N_SQ      = 8,
    parameter int CHAR_W    = 8,
    parameter int CHAR_H    = 16,
    parameter int LABEL_GAP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        flip_req,
    output logic [10:0] char_addr,
    output logic [2:0]  char_col,
    output logic        label_en,
    output logic        flipped
);

    localparam int c_SQ_I   = 1 << SQ_LOG2;
    localparam int c_SPAN_I = N_SQ * c_SQ_I;
    localparam int c_T0_I   = BOARD_Y - LABEL_GAP - CHAR_H;
    localparam int c_B0_I   = BOARD_Y + c_SPAN_I + LABEL_GAP;
    localparam int c_L0_I   = BOARD_X - LABEL_GAP - CHAR_W;
    localparam int c_R0_I   = BOARD_X + c_SPAN_I + LABEL_GAP;

    // Bands whose start would be negative are never hit.
    localparam bit          c_T_OK    = (c_T0_I >= 0);
    localparam bit          c_L_OK    = (c_L0_I >= 0);
    localparam logic [10:0] c_BX      = 11'(BOARD_X);
    localparam logic [10:0] c_BY      = 11'(BOARD_Y);
    localparam logic [10:0] c_SPAN    = 11'(c_SPAN_I);
    localparam logic [10:0] c_T0      = 11'(c_T0_I);
    localparam logic [10:0] c_B0      = 11'(c_B0_I);
    localparam logic [10:0] c_L0      = 11'(c_L0_I);
    localparam logic [10:0] c_R0      = 11'(c_R0_I);
    localparam logic [10:0] c_CH      = 11'(CHAR_H);
    localparam logic [10:0] c_CW      = 11'(CHAR_W);
    localparam logic [10:0] c_SQ_MASK = 11'(c_SQ_I - 1);
    localparam logic [10:0] c_FLO     = 11'((c_SQ_I - CHAR_W) / 2);
    localparam logic [10:0] c_FHI     = 11'((c_SQ_I + CHAR_W) / 2);
    localparam logic [10:0] c_RLO     = 11'((c_SQ_I - CHAR_H) / 2);
    localparam logic [10:0] c_RHI     = 11'((c_SQ_I + CHAR_H) / 2);

    logic        w_flip;

    // ---------------- stage 0: band decode ----------------
    logic [10:0] w_dx, w_dy, w_tl, w_bl, w_lc, w_rc;
    logic        w_in_cols, w_in_rows, w_in_top, w_in_bot, w_in_left, w_in_right;

    assign w_dx = hcount - c_BX;
    assign w_dy = vcount - c_BY;
    assign w_tl = vcount - c_T0;
    assign w_bl = vcount - c_B0;
    assign w_lc = hcount - c_L0;
    assign w_rc = hcount - c_R0;

    assign w_in_cols  = (hcount >= c_BX) && (w_dx < c_SPAN);
    assign w_in_rows  = (vcount >= c_BY) && (w_dy < c_SPAN);
    assign w_in_top   = c_T_OK && (vcount >= c_T0) && (w_tl < c_CH);
    assign w_in_bot   = (vcount >= c_B0) && (w_bl < c_CH);
    assign w_in_left  = c_L_OK && (hcount >= c_L0) && (w_lc < c_CW);
    assign w_in_right = (hcount >= c_R0) && (w_rc < c_CW);

    // ---------------- stage 1 registers ----------------
    logic        r_s1_file, r_s1_rank;
    logic [2:0]  r_s1_fidx, r_s1_ridx, r_s1_rcol;
    logic [10:0] r_s1_foff, r_s1_roff;
    logic [3:0]  r_s1_fline;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_file  <= 1'b0;
            r_s1_rank  <= 1'b0;
            r_s1_fidx  <= 3'd0;
            r_s1_ridx  <= 3'd0;
            r_s1_rcol  <= 3'd0;
            r_s1_foff  <= 11'd0;
            r_s1_roff  <= 11'd0;
            r_s1_fline <= 4'd0;
        end else begin
            r_s1_file  <= (w_in_top || w_in_bot) && w_in_cols;
            r_s1_rank  <= (w_in_left || w_in_right) && w_in_rows;
            r_s1_fidx  <= 3'(w_dx >> SQ_LOG2);
            r_s1_ridx  <= 3'(w_dy >> SQ_LOG2);
            r_s1_foff  <= w_dx & c_SQ_MASK;
            r_s1_roff  <= w_dy & c_SQ_MASK;
            r_s1_fline <= w_in_top ? w_tl[3:0] : w_bl[3:0];
            r_s1_rcol  <= w_in_left ? w_lc[2:0] : w_rc[2:0];
        end
    end

    // ---------------- stage 2: glyph select ----------------
    logic       w_fact, w_ract, w_en;
    logic [6:0] w_code;
    logic [3:0] w_line;
    logic [2:0] w_col;

    assign w_fact = r_s1_file && (r_s1_foff >= c_FLO) && (r_s1_foff < c_FHI);
    assign w_ract = r_s1_rank && (r_s1_roff >= c_RLO) && (r_s1_roff < c_RHI);

    // A file glyph takes priority if bands ever overlap.
    always_comb begin
        w_en   = 1'b0;
        w_code = 7'd0;
        w_line = 4'd0;
        w_col  = 3'd0;
        if (w_fact) begin
            w_en   = 1'b1;
            w_code = 7'h41 + {4'b0, (w_flip ? (3'(N_SQ - 1) - r_s1_fidx) : r_s1_fidx)};
            w_line = r_s1_fline;
            w_col  = 3'(r_s1_foff - c_FLO);
        end else if (w_ract) begin
            w_en   = 1'b1;
            w_code = w_flip ? (7'h31 + {4'b0, r_s1_ridx})
                            : (7'h30 + 7'(N_SQ) - {4'b0, r_s1_ridx});
            w_line = 4'(r_s1_roff - c_RLO);
            w_col  = r_s1_rcol;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_addr <= 11'd0;
            char_col  <= 3'd0;
            label_en  <= 1'b0;
        end else begin
            char_addr <= {w_code, w_line};
            char_col  <= w_col;
            label_en  <= w_en;
        end
    end

    // ---------------- flip controller ----------------
`ifdef LABEL_FLIP_EN
    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_PENDING = 1'b1;

    logic [0:0] r_state, w_state_nxt;
    logic       r_flipped, w_toggle, w_frame_start;

    assign w_frame_start = (hcount == 11'd0) && (vcount == 11'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_flipped <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_toggle)
                r_flipped <= ~r_flipped;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (flip_req && !w_frame_start) w_state_nxt = c_PENDING;
            c_PENDING: if (w_frame_start) w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    // A request coincident with frame start toggles directly from IDLE.
    always_comb begin
        w_toggle = 1'b0;
        if (w_frame_start && ((r_state == c_PENDING) || flip_req))
            w_toggle = 1'b1;
    end

    assign w_flip = r_flipped;
`else
    logic w_unused_flip_req;
    assign w_unused_flip_req = flip_req;
    assign w_flip = 1'b0;
`endif

    assign flipped = w_flip;

endmodule
`default_nettype wire

// File: tb/tb_board_label_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_label_gen
// Function : scoreboard bench for board_label_gen (default geometry);
//            flip scenarios are exercised when LABEL_FLIP_EN is defined.
// Revision : 1.0
// ============================================================================
module tb_board_label_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] hcount = 11'd0;
    logic [10:0] vcount = 11'd0;
    logic        flip_req = 1'b0;
    logic [10:0] char_addr;
    logic [2:0]  char_col;
    logic        label_en;
    logic        flipped;

    board_label_gen u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .flip_req  (flip_req),
        .char_addr (char_addr),
        .char_col  (char_col),
        .label_en  (label_en),
        .flipped   (flipped)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [10:0] addr;
        logic [2:0]  col;
        logic        en;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   tb_flip = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model written directly against the default board geometry.
    function automatic exp_t model(input int h, input int v, input bit fl);
        exp_t e;
        int dx, dy, o, p, code, line, col;
        e.due = 0; e.addr = 11'd0; e.col = 3'd0; e.en = 1'b0;
        code = -1; line = 0; col = 0;
        if (((v >= 104 && v <= 119) || (v >= 648 && v <= 663)) && h >= 256 && h < 768) begin
            dx = h - 256; o = dx % 64;
            if (o >= 28 && o <= 35) begin
                code = fl ? (72 - dx / 64) : (65 + dx / 64);
                line = (v <= 119) ? v - 104 : v - 648;
                col  = o - 28;
            end
        end
        if (code < 0 && ((h >= 240 && h <= 247) || (h >= 776 && h <= 783)) && v >= 128 && v < 640) begin
            dy = v - 128; p = dy % 64;
            if (p >= 24 && p <= 39) begin
                code = fl ? (49 + dy / 64) : (56 - dy / 64);
                line = p - 24;
                col  = (h <= 247) ? h - 240 : h - 776;
            end
        end
        if (code >= 0) begin
            e.addr = 11'(code * 16 + line);
            e.col  = 3'(col);
            e.en   = 1'b1;
        end
        return e;
    endfunction

    task automatic send(input int h, input int v, input bit req);
        exp_t e;
        @(posedge clk);
        #1;
        hcount   = 11'(h);
        vcount   = 11'(v);
        flip_req = req;
        e = model(h, v, tb_flip);
        e.due = cyc + 2;
        sb_q.push_back(e);
    endtask

    task automatic send_exp(input int h, input int v, input logic [10:0] addr, input logic [2:0] col);
        exp_t e;
        @(posedge clk);
        #1;
        hcount   = 11'(h);
        vcount   = 11'(v);
        flip_req = 1'b0;
        e.due = cyc + 2; e.addr = addr; e.col = col; e.en = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic sweep(input int n);
        int h, v;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(1, 0) == 0) begin
                h = $urandom_range(790, 230);
                v = ($urandom_range(1, 0) == 0) ? $urandom_range(124, 100) : $urandom_range(668, 644);
            end else begin
                h = ($urandom_range(1, 0) == 0) ? $urandom_range(250, 236) : $urandom_range(787, 772);
                v = $urandom_range(650, 120);
            end
            send(h, v, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            mon_e = sb_q.pop_front();
            check_value("char_addr", 32'(char_addr), 32'(mon_e.addr));
            check_value("char_col",  32'(char_col),  32'(mon_e.col));
            check_value("label_en",  32'(label_en),  32'(mon_e.en));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_value("rst_addr",  32'(char_addr), 32'd0);
        check_value("rst_col",   32'(char_col),  32'd0);
        check_value("rst_en",    32'(label_en),  32'd0);
        check_value("rst_flip",  32'(flipped),   32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed points, then boundaries around glyph cells.
        send_exp(284, 110, 11'h416, 3'd0);
        send_exp(242, 157, 11'h385, 3'd2);
        send(300, 110, 1'b0);
        send_exp(739, 663, 11'h48F, 3'd7);
        send(283, 110, 1'b0);
        send(291, 110, 1'b0);
        send(292, 110, 1'b0);
        send(284, 103, 1'b0);
        send(284, 120, 1'b0);
        send(239, 157, 1'b0);
        send(248, 157, 1'b0);
        send(242, 152, 1'b0);
        send(242, 167, 1'b0);
        send(242, 168, 1'b0);
        send(783, 600, 1'b0);
        send(784, 600, 1'b0);
        send(242, 127, 1'b0);
        send(242, 640, 1'b0);
        sweep(120);

`ifdef LABEL_FLIP_EN
        // Mid-frame request is held until frame start.
        send(500, 300, 1'b1);
        send(284, 110, 1'b0);
        @(negedge clk);
        check_value("flip_hold", 32'(flipped), 32'd0);
        send(600, 300, 1'b0);
        send(0, 0, 1'b0);
        @(negedge clk);
        check_value("flip_pre_fs", 32'(flipped), 32'd0);
        tb_flip = 1'b1;
        send(5, 5, 1'b0);
        @(negedge clk);
        check_value("flip_post_fs", 32'(flipped), 32'd1);
        send_exp(284, 110, 11'h486, 3'd0);
        send_exp(242, 157, 11'h315, 3'd2);
        sweep(60);

        // Several requests in one frame give a single toggle.
        send(500, 300, 1'b1);
        send(510, 300, 1'b1);
        send(520, 300, 1'b1);
        send(0, 0, 1'b0);
        tb_flip = 1'b0;
        send(5, 5, 1'b0);
        @(negedge clk);
        check_value("debounce_toggle", 32'(flipped), 32'd0);
        send(0, 0, 1'b0);
        send(5, 5, 1'b0);
        @(negedge clk);
        check_value("debounce_single", 32'(flipped), 32'd0);

        // Request coincident with frame start.
        send(0, 0, 1'b1);
        @(negedge clk);
        check_value("coinc_pre", 32'(flipped), 32'd0);
        tb_flip = 1'b1;
        send(5, 5, 1'b0);
        @(negedge clk);
        check_value("coinc_toggle", 32'(flipped), 32'd1);
        send(0, 0, 1'b0);
        send(5, 5, 1'b0);
        @(negedge clk);
        check_value("coinc_idle", 32'(flipped), 32'd1);
        send(284, 110, 1'b0);
`else
        send(500, 300, 1'b1);
        send(0, 0, 1'b0);
        send(5, 5, 1'b0);
        @(negedge clk);
        check_value("noflip_tied", 32'(flipped), 32'd0);
        send_exp(284, 110, 11'h416, 3'd0);
`endif

        // Reset with a label pixel in flight and a flip pending.
        send(284, 110, 1'b0);
        send(500, 300, 1'b1);
        @(posedge clk);
        #3;
        sb_q.delete();
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_addr", 32'(char_addr), 32'd0);
        check_value("mid_rst_col",  32'(char_col),  32'd0);
        check_value("mid_rst_en",   32'(label_en),  32'd0);
        check_value("mid_rst_flip", 32'(flipped),   32'd0);
        tb_flip = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 0, 1'b0);
        send(5, 5, 1'b0);
        @(negedge clk);
        check_value("rst_no_toggle", 32'(flipped), 32'd0);
        send_exp(284, 110, 11'h416, 3'd0);
        sweep(20);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check_value("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_label_gen.md
# board_label_gen

Parametrised, pipelined generator of the file (A–H) and rank (1–8) labels drawn around the chessboard. It sits in the VGA draw path between the timing generator and the font ROM. Each pixel's hcount/vcount becomes a registered font ROM address, a glyph column index and a label-enable flag. Board geometry is set by parameters, and the block supports a frame-synchronous board-flip (black-side view).

## Interface
- BOARD_X, 256: left edge of the board, pixels
- BOARD_Y, 128: top edge of the board, pixels
- SQ_LOG2, 6: log2 of the square size; square = 64 px
- N_SQ, 8: squares per side (≤ 8)
- CHAR_W, 8: glyph width, pixels; must be a power of two ≤ 8
- CHAR_H, 16: glyph height, pixels; must be 16, matching the 4-bit line field
- LABEL_GAP, 8: gap between the board edge and the label band, pixels

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous reset, active-low
- hcount  in  11  current pixel column
- vcount  in  11  current pixel row
- flip_req  in  1  one-cycle request to toggle board orientation
- char_addr  out  11  font ROM address {char_code[6:0], line[3:0]}; 0 when not in a glyph
- char_col  out  3  pixel column inside the glyph, 0..CHAR_W-1; 0 when not in a glyph
- label_en  out  1  current pixel lies inside a label glyph cell
- flipped  out  1  current board orientation; 1 = black at bottom

## Operation
- Top band: rows T0 = BOARD_Y-LABEL_GAP-CHAR_H .. T0+CHAR_H-1 (104..119 with defaults).
- Bottom band: rows B0 = BOARD_Y+N_SQ·2^SQ_LOG2+LABEL_GAP .. B0+CHAR_H-1 (648..663).
- In the top/bottom bands, for BOARD_X ≤ hcount < BOARD_X+N_SQ·SQ:
  - dx = hcount-BOARD_X; f = dx>>SQ_LOG2; o = dx mod SQ.
  - Glyph is active when (SQ-CHAR_W)/2 ≤ o < (SQ+CHAR_W)/2, i.e. 28..35 with defaults.
  - code = "A"+f, or "A"+N_SQ-1-f when flipped.
  - line = vcount-band start; col = o-(SQ-CHAR_W)/2.
- Left band: columns L0 = BOARD_X-LABEL_GAP-CHAR_W .. L0+CHAR_W-1 (240..247).
- Right band: columns R0 = BOARD_X+N_SQ·SQ+LABEL_GAP .. R0+CHAR_W-1 (776..783).
- In the left/right bands, for BOARD_Y ≤ vcount < BOARD_Y+N_SQ·SQ:
  - dy = vcount-BOARD_Y; r = dy>>SQ_LOG2; p = dy mod SQ.
  - Glyph is active when (SQ-CHAR_H)/2 ≤ p < (SQ+CHAR_H)/2, i.e. 24..39.
  - code = "0"+N_SQ-r, or "1"+r when flipped.
  - line = p-(SQ-CHAR_H)/2; col = hcount-band start.
- Corner overlaps between bands are impossible with legal parameters. If an overlap does occur, the file label wins.
- When no glyph is active: char_addr = 0, char_col = 0, label_en = 0.
- All arithmetic is unsigned and 11 bits wide. Band bounds are compile-time constants. Operands that go negative are treated as outside.
- Flip controller, states IDLE and PENDING:
  - flip_req in IDLE moves the controller to PENDING.
  - Frame start is hcount==0 && vcount==0 sampled at stage 0.
  - At frame start, PENDING toggles flipped and returns to IDLE.
  - flip_req sampled in the same cycle as frame start toggles immediately and does not enter PENDING.
  - Further flip_req while PENDING is absorbed; only one toggle occurs per frame.
  - Orientation therefore never changes mid-frame.

## Timing
- Two-stage pipeline; latency is 2 clk from hcount/vcount to char_addr, char_col and label_en.
- Stage 1 registers band hit, index (f or r), in-square offset and band-relative coordinate.
- Stage 2 registers the final outputs.
- The flipped value used for a pixel is the one valid at stage 1 of that pixel.
- flipped output updates 1 clk after the frame-start sample.
- Reset values: char_addr = 0, char_col = 0, label_en = 0, flipped = 0, controller in IDLE, all pipeline registers cleared.
- Reset asserted mid-frame clears a PENDING flip. Outputs are 0 until 2 clk after rst_n deasserts.

## Configuration
- LABEL_FLIP_EN defined: flip controller built as described above.
- LABEL_FLIP_EN undefined:
  - flip_req is ignored and flipped is tied to 0.
  - No PENDING state or flip register is built.
  - Codes always follow the unflipped mapping.

## Test plan
- hcount=284, vcount=110 held 2 clk -> char_addr=0x416 ("A", line 6), char_col=0, label_en=1.
- hcount=242, vcount=157 -> char_addr=0x385 ("8", line 5), char_col=2, label_en=1; hcount=300, vcount=110 -> char_addr=0, label_en=0.
- hcount=739, vcount=663 -> char_addr=0x48F ("H", line 15), char_col=7.
- Flip timing: pulse flip_req mid-frame -> flipped stays 0 until frame start, then 1. Next frame, hcount=284, vcount=110 -> char_addr=0x486 ("H"); hcount=242, vcount=157 -> 0x315 ("1").
- Flip debounce: three flip_req pulses in one frame -> exactly one toggle. flip_req coincident with frame start -> toggle 1 clk later, controller stays IDLE.
- Reset: assert rst_n=0 with PENDING set -> all outputs 0 immediately and flipped=0; the frame start after release produces no toggle.
